// File: rtl/pixel_frame_streamer.sv
// Frame buffer plus row-major pixel streamer feeding the feature extractor.
// Host loads the buffer; go sends one frame and waits for the extractor's done pulse.
module pixel_frame_streamer #(
    parameter int unsigned IMG_WIDTH  = 32,
    parameter int unsigned IMG_HEIGHT = 32,
    parameter int unsigned PIX_W      = 8,
    parameter int unsigned GAP        = 0,
    parameter int unsigned ADDR_W     = $clog2(IMG_WIDTH * IMG_HEIGHT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [PIX_W-1:0]  wr_data,
    output logic              wr_drop,
    input  logic              go,
    output logic              busy,
    output logic              start_signal,
    output logic              pixel_valid_out,
    output logic [PIX_W-1:0]  pixel_out,
    input  logic              done_in,
    output logic              frame_done
);
    localparam int unsigned NPIX  = IMG_WIDTH * IMG_HEIGHT;
    localparam int unsigned IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int unsigned X_W   = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam int unsigned Y_W   = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int unsigned G_W   = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_STREAM    = 3'd2;
    localparam logic [2:0] S_GAP       = 3'd3;
    localparam logic [2:0] S_WAIT_DONE = 3'd4;

    logic [PIX_W-1:0] mem [NPIX];

    logic [2:0]     state, nxt;
    logic [X_W-1:0] x, x_d;
    logic [Y_W-1:0] y, y_d;
    logic [G_W-1:0] gap_cnt, gap_d;
    logic           done_lat, lat_d;
    logic           last_px, last_d;
    logic           busy_d, start_d, fd_d, drop_d;
    logic           emit, wr_ok, done_any, x_end, y_end;
    logic [IDX_W-1:0] rd_idx;

    assign wr_ok    = wr_en && !busy && (32'(wr_addr) < NPIX);
    assign done_any = done_lat || done_in;
    assign x_end    = (32'(x) == IMG_WIDTH - 1);
    assign y_end    = (32'(y) == IMG_HEIGHT - 1);
    assign rd_idx   = IDX_W'(32'(y) * IMG_WIDTH + 32'(x));

    // Frame buffer: never reset, so a loaded frame survives rst
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end

    // Next-state and next-output logic
    always_comb begin
        nxt     = state;
        x_d     = x;
        y_d     = y;
        gap_d   = gap_cnt;
        lat_d   = done_lat || (busy && done_in);
        last_d  = last_px;
        busy_d  = busy;
        start_d = 1'b0;
        fd_d    = 1'b0;
        emit    = 1'b0;
        drop_d  = wr_en && !wr_ok;

        case (state)
            S_IDLE: begin
                if (go) begin
                    nxt     = S_START;
                    busy_d  = 1'b1;
                    start_d = 1'b1;
                    x_d     = '0;
                    y_d     = '0;
                    lat_d   = 1'b0;
                end
            end
            S_START: begin
                emit = 1'b1;
                nxt  = S_STREAM;
            end
            S_STREAM: begin
                // A done already seen is honoured on the way into WAIT_DONE
                if (last_px) begin
                    nxt  = S_WAIT_DONE;
                    fd_d = done_any;
                end else if (GAP == 0) begin
                    emit = 1'b1;
                end else begin
                    nxt   = S_GAP;
                    gap_d = '0;
                end
            end
            S_GAP: begin
                if (32'(gap_cnt) == GAP - 1) begin
                    emit = 1'b1;
                    nxt  = S_STREAM;
                end else begin
                    gap_d = gap_cnt + G_W'(1);
                end
            end
            S_WAIT_DONE: begin
                if (frame_done) begin
                    nxt    = S_IDLE;
                    busy_d = 1'b0;
                    lat_d  = 1'b0;
                end else if (done_any) begin
                    fd_d = 1'b1;
                end
            end
            default: nxt = S_IDLE;
        endcase

        if (emit) begin
            last_d = x_end && y_end;
            if (x_end) begin
                x_d = '0;
                y_d = y_end ? '0 : y + Y_W'(1);
            end else begin
                x_d = x + X_W'(1);
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            x               <= '0;
            y               <= '0;
            gap_cnt         <= '0;
            done_lat        <= 1'b0;
            last_px         <= 1'b0;
            busy            <= 1'b0;
            start_signal    <= 1'b0;
            pixel_valid_out <= 1'b0;
            pixel_out       <= '0;
            frame_done      <= 1'b0;
            wr_drop         <= 1'b0;
        end else begin
            state           <= nxt;
            x               <= x_d;
            y               <= y_d;
            gap_cnt         <= gap_d;
            done_lat        <= lat_d;
            last_px         <= last_d;
            busy            <= busy_d;
            start_signal    <= start_d;
            pixel_valid_out <= emit;
            frame_done      <= fd_d;
            wr_drop         <= drop_d;
            if (emit) pixel_out <= mem[rd_idx];
        end
    end
endmodule
